// File: rtl/wait_event_sequencer.sv
// Queues wait-for-edge commands, issues each to the wait stage and returns OK/TIMEOUT/BADIDX with elapsed cycles.
// Latency: accept at N -> start pulse at N+2; cmd_ready drops when the FIFO is full, RESP holds until rsp_ready.
module wait_event_sequencer #(
  parameter int WAIT_SIZE  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_op,
  input  logic [7:0]  i_cmd_idx,
  input  logic [31:0] i_cmd_timeout,
  output logic        o_en_wait_event,
  output logic [31:0] o_wait_en,
  output logic        o_sel_wtr_wtf,
  output logic [31:0] o_max_timeout,
  input  logic        i_wait_done,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [1:0]  o_rsp_status,
  output logic [31:0] o_rsp_cycles,
  output logic        o_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] WAIT_LIM = 32'(WAIT_SIZE);
  localparam logic [32:0] GUARD33  = 33'(GUARD);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADIDX  = 2'b10;

  typedef struct packed {
    logic        op;
    logic [7:0]  idx;
    logic [31:0] timeout;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  cmd_t             mem [FIFO_DEPTH];
  cmd_t             cmd_in;
  cmd_t             cur;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, fifo_empty;

  logic [31:0] cnt;
  logic [32:0] cnt_inc, limit;
  logic [31:0] cnt_sat;
  logic        bad_idx, wd_hit;
  logic        set_bad, fin_ok, fin_to;
  logic [1:0]  status;
  logic [31:0] cycles;

  assign cmd_in      = {i_cmd_op, i_cmd_idx, i_cmd_timeout};
  assign fifo_empty  = (count == '0);
  assign o_cmd_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push        = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bad_idx = ({24'd0, cur.idx} >= WAIT_LIM);
  assign cnt_inc = {1'b0, cnt} + 33'd1;
  assign cnt_sat = cnt_inc[32] ? 32'hFFFF_FFFF : cnt_inc[31:0];
  assign limit   = {1'b0, cur.timeout} + GUARD33;
  assign wd_hit  = (cur.timeout != 32'd0) && (cnt_inc == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    pop             = 1'b0;
    o_en_wait_event = 1'b0;
    set_bad         = 1'b0;
    fin_ok          = 1'b0;
    fin_to          = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bad_idx) begin
          set_bad   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          o_en_wait_event = 1'b1;
          state_nxt       = S_WAIT;
        end
      end
      S_WAIT: begin
        // Completion beats a coincident watchdog expiry.
        if (i_wait_done) begin
          fin_ok    = 1'b1;
          state_nxt = S_RESP;
        end else if (wd_hit) begin
          fin_to    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      cnt    <= '0;
      status <= '0;
      cycles <= '0;
    end else begin
      if (pop) cur <= mem[rd_ptr];
      if (state == S_ISSUE)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt_sat;
      if (set_bad) begin
        status <= ST_BADIDX;
        cycles <= '0;
      end else if (fin_ok) begin
        status <= ST_OK;
        cycles <= cnt_sat;
      end else if (fin_to) begin
        status <= ST_TIMEOUT;
        cycles <= cnt_sat;
      end
    end
  end

  logic hold;
  assign hold          = (state == S_ISSUE) || (state == S_WAIT);
  assign o_wait_en     = hold ? {24'd0, cur.idx} : 32'd0;
  assign o_sel_wtr_wtf = hold ? cur.op : 1'b0;
  assign o_max_timeout = hold ? cur.timeout : 32'd0;
  assign o_rsp_valid   = (state == S_RESP);
  assign o_rsp_status  = status;
  assign o_rsp_cycles  = cycles;
  assign o_busy        = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_wait_event_sequencer.sv
// Directed bench for wait_event_sequencer: latency, OK/TIMEOUT/BADIDX, FIFO full, watchdog disable, reset flush.
module tb_wait_event_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_op;
  logic [7:0]  i_cmd_idx;
  logic [31:0] i_cmd_timeout;
  logic        o_en_wait_event;
  logic [31:0] o_wait_en;
  logic        o_sel_wtr_wtf;
  logic [31:0] o_max_timeout;
  logic        i_wait_done;
  logic        o_rsp_valid, i_rsp_ready;
  logic [1:0]  o_rsp_status;
  logic [31:0] o_rsp_cycles;
  logic        o_busy;

  int tests = 0;
  int fails = 0;

  wait_event_sequencer #(.WAIT_SIZE(5), .FIFO_DEPTH(4), .GUARD(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
    .i_cmd_idx(i_cmd_idx), .i_cmd_timeout(i_cmd_timeout),
    .o_en_wait_event(o_en_wait_event), .o_wait_en(o_wait_en),
    .o_sel_wtr_wtf(o_sel_wtr_wtf), .o_max_timeout(o_max_timeout),
    .i_wait_done(i_wait_done), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_status(o_rsp_status), .o_rsp_cycles(o_rsp_cycles), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench hung");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic op, input logic [7:0] idx, input logic [31:0] to);
    i_cmd_op      = op;
    i_cmd_idx     = idx;
    i_cmd_timeout = to;
  endtask

  task automatic send(input logic op, input logic [7:0] idx, input logic [31:0] to);
    set_cmd(op, idx, to);
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !o_cmd_ready; k++) step();
    check("send_ready", o_cmd_ready, 1);
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    for (int k = 0; k < 20 && !o_en_wait_event; k++) step();
    check(tag, o_en_wait_event, 1);
  endtask

  task automatic wait_rsp(input int lim);
    for (int k = 0; k < lim && !o_rsp_valid; k++) step();
  endtask

  task automatic release_rsp();
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
  endtask

  logic [1:0]  got_st [6];
  logic [31:0] got_cy [6];
  logic [1:0]  exp_st [6] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
  logic [31:0] exp_cy [6] = '{32'd6, 32'd0, 32'd20, 32'd0, 32'd18, 32'd0};

  initial begin
    int  nrsp;
    bit  acc, seen;

    rst_n = 1'b0; i_cmd_valid = 1'b0; i_wait_done = 1'b0; i_rsp_ready = 1'b0;
    set_cmd(1'b0, 8'd0, 32'd0);
    step(); step();
    check("rst_cmd_ready", o_cmd_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_en", o_en_wait_event, 0);

    // WTR idx 2, accepted on the very first edge after reset release
    rst_n = 1'b1;
    set_cmd(1'b0, 8'd2, 32'd100);
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
    check("lat_n1_en", o_en_wait_event, 0);
    check("lat_n1_busy", o_busy, 1);
    step();
    check("lat_n2_en", o_en_wait_event, 1);
    check("wtr_wait_en", o_wait_en, 2);
    check("wtr_sel", o_sel_wtr_wtf, 0);
    check("wtr_max_to", o_max_timeout, 100);
    step();
    check("pulse_one_cycle", o_en_wait_event, 0);
    check("hold_wait_en", o_wait_en, 2);
    for (int k = 0; k < 9; k++) step();
    check("wtr_no_rsp_yet", o_rsp_valid, 0);
    i_wait_done = 1'b1;
    step();
    i_wait_done = 1'b0;
    check("wtr_rsp_valid", o_rsp_valid, 1);
    check("wtr_status", o_rsp_status, 0);
    check("wtr_cycles", o_rsp_cycles, 10);
    step(); step();
    check("rsp_held_valid", o_rsp_valid, 1);
    check("rsp_held_cycles", o_rsp_cycles, 10);
    release_rsp();
    check("rsp_released", o_rsp_valid, 0);

    // WTF timeout
    send(1'b1, 8'd1, 32'd20);
    wait_pulse("wtf_pulse");
    check("wtf_sel", o_sel_wtr_wtf, 1);
    check("wtf_wait_en", o_wait_en, 1);
    wait_rsp(100);
    check("to_rsp_valid", o_rsp_valid, 1);
    check("to_status", o_rsp_status, 1);
    check("to_cycles", o_rsp_cycles, 36);
    release_rsp();

    // bad index
    send(1'b0, 8'd7, 32'd50);
    seen = 1'b0;
    for (int k = 0; k < 8 && !o_rsp_valid; k++) begin
      if (o_en_wait_event) seen = 1'b1;
      step();
    end
    check("bad_no_pulse", seen, 0);
    check("bad_rsp_valid", o_rsp_valid, 1);
    check("bad_status", o_rsp_status, 2);
    check("bad_cycles", o_rsp_cycles, 0);
    release_rsp();

    // FIFO fills while the FSM waits on command A
    send(1'b0, 8'd0, 32'd0);
    wait_pulse("a_pulse");
    i_cmd_valid = 1'b1;
    set_cmd(1'b0, 8'd9, 32'd0);
    check("full_ready0", o_cmd_ready, 1);
    step();
    set_cmd(1'b0, 8'd3, 32'd4);
    step();
    set_cmd(1'b1, 8'd8, 32'd0);
    step();
    set_cmd(1'b1, 8'd0, 32'd2);
    step();
    check("full_ready_low", o_cmd_ready, 0);
    set_cmd(1'b0, 8'd10, 32'd0);
    step();
    check("full_ready_low2", o_cmd_ready, 0);
    step();
    check("full_busy", o_busy, 1);
    i_wait_done = 1'b1;
    step();
    i_wait_done = 1'b0;
    i_rsp_ready = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 300 && nrsp < 6; k++) begin
      if (o_rsp_valid) begin
        got_st[nrsp] = o_rsp_status;
        got_cy[nrsp] = o_rsp_cycles;
        nrsp++;
      end
      acc = i_cmd_valid && o_cmd_ready;
      step();
      if (acc) i_cmd_valid = 1'b0;
    end
    i_rsp_ready = 1'b0;
    check("order_count", nrsp, 6);
    for (int k = 0; k < 6; k++) begin
      if (k < nrsp) begin
        check($sformatf("order_status_%0d", k), got_st[k], exp_st[k]);
        check($sformatf("order_cycles_%0d", k), got_cy[k], exp_cy[k]);
      end
    end
    check("drained_busy", o_busy, 0);

    // watchdog disabled with timeout 0
    send(1'b0, 8'd4, 32'd0);
    wait_pulse("nt_pulse");
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (o_rsp_valid) seen = 1'b1;
    end
    check("nt_no_early_rsp", seen, 0);
    i_wait_done = 1'b1;
    step();
    i_wait_done = 1'b0;
    check("nt_status", o_rsp_status, 0);
    check("nt_cycles", o_rsp_cycles, 1000);
    release_rsp();

    // done coincides with watchdog expiry
    send(1'b0, 8'd2, 32'd20);
    wait_pulse("tie_pulse");
    for (int k = 0; k < 36; k++) step();
    check("tie_no_rsp_yet", o_rsp_valid, 0);
    i_wait_done = 1'b1;
    step();
    i_wait_done = 1'b0;
    check("tie_rsp_valid", o_rsp_valid, 1);
    check("tie_status", o_rsp_status, 0);
    check("tie_cycles", o_rsp_cycles, 36);
    release_rsp();

    // reset mid-WAIT with three commands queued
    send(1'b0, 8'd1, 32'd0);
    wait_pulse("rw_pulse");
    send(1'b0, 8'd2, 32'd0);
    send(1'b1, 8'd3, 32'd0);
    send(1'b0, 8'd4, 32'd0);
    check("rw_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rw_rst_ready", o_cmd_ready, 1);
    check("rw_rst_busy", o_busy, 0);
    check("rw_rst_wait_en", o_wait_en, 0);
    check("rw_rst_max_to", o_max_timeout, 0);
    check("rw_rst_sel", o_sel_wtr_wtf, 0);
    check("rw_rst_status", o_rsp_status, 0);
    check("rw_rst_cycles", o_rsp_cycles, 0);
    step(); step();
    rst_n = 1'b1;
    i_wait_done = 1'b1;
    i_rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_rsp_valid || o_en_wait_event || o_busy) seen = 1'b1;
    end
    i_wait_done = 1'b0;
    i_rsp_ready = 1'b0;
    check("rw_no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wait_event_sequencer.md
WAIT_EVENT_SEQUENCER -- requirements
Module: wait_event_sequencer

Interface
REQ-001 SHALL have parameter WAIT_SIZE, default 5: number of selectable wait signals in the downstream wait stage.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: command FIFO depth; power of 2, minimum 2.
REQ-003 SHALL have parameter GUARD, default 16: watchdog margin in cycles added to the command timeout.
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as in the codebase: clk, rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  FIFO can accept a command.
- i_cmd_op  in  1  edge type: 0 = WTR (wait rising), 1 = WTF (wait falling).
- i_cmd_idx  in  8  wait signal index.
- i_cmd_timeout  in  32  timeout in cycles; 0 = no timeout.
- o_en_wait_event  out  1  one-cycle start pulse to the wait stage.
- o_wait_en  out  32  selected index to the wait stage.
- o_sel_wtr_wtf  out  1  edge select to the wait stage.
- o_max_timeout  out  32  timeout to the wait stage.
- i_wait_done  in  1  completion from the wait stage.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed.
- o_rsp_status  out  2  00 OK, 01 TIMEOUT, 10 BADIDX.
- o_rsp_cycles  out  32  cycles from start pulse to completion.
- o_busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-006 A command SHALL be written into the FIFO on a clk edge where i_cmd_valid and o_cmd_ready are both 1; o_cmd_ready = FIFO not full.
REQ-007 A pop and a push in the same cycle SHALL both take effect; FIFO occupancy SHALL remain in 0..FIFO_DEPTH and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-008 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-009 IDLE: if FIFO non-empty, SHALL pop the head, register its fields, and go to ISSUE; otherwise stay in IDLE.
REQ-010 ISSUE: if idx >= WAIT_SIZE, SHALL set status BADIDX and cycles 0, SHALL not pulse o_en_wait_event, and SHALL go to RESP.
REQ-011 ISSUE with a valid idx: SHALL drive o_en_wait_event = 1 for exactly one cycle, clear the cycle counter to 0, and go to WAIT.
REQ-012 o_wait_en, o_sel_wtr_wtf and o_max_timeout SHALL hold the registered command from ISSUE through the end of WAIT.
REQ-013 WAIT: the cycle counter SHALL increment by 1 each cycle and saturate at 0xFFFFFFFF.
REQ-014 WAIT: on i_wait_done = 1, SHALL set status OK, capture cycles = counter + 1, and go to RESP.
REQ-015 WAIT with timeout != 0: when counter + 1 = timeout + GUARD (33-bit compare, no wrap) and i_wait_done = 0, SHALL set status TIMEOUT, capture cycles, and go to RESP.
REQ-016 If i_wait_done and watchdog expiry occur in the same cycle, OK SHALL win.
REQ-017 With timeout = 0 the watchdog SHALL be disabled; WAIT exits only on i_wait_done.
REQ-018 i_wait_done SHALL be ignored in every state other than WAIT.
REQ-019 RESP: o_rsp_valid = 1 with o_rsp_status and o_rsp_cycles stable until i_rsp_ready = 1; then the FSM SHALL go to IDLE.
REQ-020 Pipeline latency: command accepted at cycle N into an empty FIFO with the FSM in IDLE -> o_en_wait_event at cycle N+2.
REQ-021 The FIFO SHALL keep accepting commands while the FSM is in WAIT or RESP.

Reset
REQ-022 While rst_n = 0, asynchronously: FSM = IDLE, FIFO empty, pointers 0.
REQ-023 While rst_n = 0, all outputs SHALL be 0 except o_cmd_ready = 1.
REQ-024 Reset asserted mid-WAIT or mid-RESP SHALL discard the in-flight command, all queued commands, and any pending response.
REQ-025 After rst_n deasserts, the first command SHALL be accepted on the first clk edge.

Verification
REQ-026 WTR idx=2 timeout=100; i_wait_done 10 cycles after the start pulse -> one o_en_wait_event pulse with o_wait_en=2 and o_sel_wtr_wtf=0; response OK, cycles=10.
REQ-027 WTF idx=1 timeout=20 with GUARD=16; i_wait_done never asserted -> response TIMEOUT, cycles=36.
REQ-028 idx=7 with WAIT_SIZE=5 -> no start pulse; response BADIDX, cycles=0.
REQ-029 Push 5 commands back-to-back with FIFO_DEPTH=4 while the FSM is busy -> o_cmd_ready=0 after 4 are held; all responses returned in order.
REQ-030 timeout=0 with i_wait_done at cycle 1000 -> response OK, cycles=1000; i_wait_done and watchdog expiry in the same cycle -> OK.
REQ-031 rst_n pulsed low during WAIT with 3 commands queued -> all outputs return to reset values and no stale response appears after reset.
